fadd_issue: RTL

FADD_ISSUE -- requirements
Module: fadd_issue

---
 rtl/fadd_issue_if.sv | 17 +
 rtl/fadd_issue.sv | 57 +++++
 2 files changed

// File: rtl/fadd_issue_if.sv
// fadd_issue_if: request/result handshake bundle between a requester and the fadd issue stage
interface fadd_issue_if #(parameter int TAG_W = 5);
   logic             in_valid;
   logic             in_ready;
   logic             in_op;
   logic [31:0]      in_x1;
   logic [31:0]      in_x2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_y;
   logic [TAG_W-1:0] out_tag;
   modport master(output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
                  input in_ready, out_valid, out_y, out_tag);
   modport slave(input in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
                 output in_ready, out_valid, out_y, out_tag);
endinterface

// File: rtl/fadd_issue.sv
// fadd_issue: issues one add/sub to an external float adder, holds operands, returns tagged result
module fadd_issue #(parameter int TAG_W = 5) (
   input  logic        clk,
   input  logic        rstn,
   fadd_issue_if.slave io,
   input  logic        flush,
   output logic [31:0] fadd_x1,
   output logic [31:0] fadd_x2,
   input  logic [31:0] fadd_y,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t           state;
   logic [TAG_W-1:0] tag;
   logic             acc;
   // accept when idle or when the held result leaves this cycle; flush blocks new work
   always_comb begin
      io.in_ready = ~flush & ((state == IDLE) | ((state == DONE) & io.out_ready));
      acc         = io.in_valid & io.in_ready;
      busy        = state != IDLE;
   end
   // issue FSM: operands load only on accept so the adder bypass keeps seeing them
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         io.out_valid <= 1'b0;
         io.out_y     <= '0;
         io.out_tag   <= '0;
         fadd_x1      <= '0;
         fadd_x2      <= '0;
         tag          <= '0;
      end else if (flush) begin
         state        <= IDLE;
         io.out_valid <= 1'b0;
      end else begin
         if (acc) begin
            fadd_x1 <= io.in_x1;
            fadd_x2 <= {io.in_x2[31] ^ io.in_op, io.in_x2[30:0]};
            tag     <= io.in_tag;
         end
         case (state)
            IDLE: if (acc) state <= EXEC;
            EXEC: begin
               io.out_y     <= fadd_y;
               io.out_tag   <= tag;
               io.out_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: if (io.out_ready) begin
               io.out_valid <= 1'b0;
               state        <= io.in_valid ? EXEC : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
